// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with byte-lane enables and a fixed number of wait states.
// Each accepted read or write request is answered by a one-cycle o_ready strobe.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_AMOUNT  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd,
  input  logic                  i_we,
  input  logic [3:0]            i_ctrl,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ready,
  output logic                  o_err
);

  localparam int AW = (RAM_AMOUNT > 1) ? $clog2(RAM_AMOUNT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [3:0] ctrl);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{ctrl[b]}};
    return m;
  endfunction

  function automatic logic req_error(input logic rd, input logic we,
                                     input logic [3:0] ctrl, input logic [29:0] widx);
    return (widx >= 30'(RAM_AMOUNT)) || (ctrl == 4'b0000) || (rd && we);
  endfunction

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d, we_q, we_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [29:0]           widx_q, widx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ready_q, ready_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [RAM_AMOUNT];

  logic                  eff_rd, eff_we, eff_err, commit, mem_we;
  logic [3:0]            eff_ctrl;
  logic [29:0]           eff_widx;
  logic [DATA_WIDTH-1:0] eff_wdata, eff_mask, mem_word;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^i_addr[1:0];

  // With zero wait states the response is formed on the accepting edge, so the
  // live inputs stand in for the not-yet-latched request while in IDLE.
  always_comb begin
    eff_rd    = (state_q == IDLE) ? i_rd           : rd_q;
    eff_we    = (state_q == IDLE) ? i_we           : we_q;
    eff_ctrl  = (state_q == IDLE) ? i_ctrl         : ctrl_q;
    eff_widx  = (state_q == IDLE) ? i_addr[31:2]   : widx_q;
    eff_wdata = (state_q == IDLE) ? i_wdata        : wdata_q;
    eff_err   = req_error(eff_rd, eff_we, eff_ctrl, eff_widx);
    eff_mask  = lane_mask(eff_ctrl);
    mem_word  = mem_q[eff_widx[AW-1:0]];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    we_d    = we_q;
    ctrl_d  = ctrl_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    commit  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rd || i_we) begin
          rd_d    = i_rd;
          we_d    = i_we;
          ctrl_d  = i_ctrl;
          widx_d  = i_addr[31:2];
          wdata_d = i_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Response and storage update are both decided on the edge entering RESP.
    if (commit) begin
      ready_d = 1'b1;
      err_d   = eff_err;
      rdata_d = (eff_rd && !eff_err) ? (mem_word & eff_mask) : '0;
      mem_we  = eff_we && !eff_err && rst_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    ctrl_q  <= ctrl_d;
    widx_q  <= widx_d;
    wdata_q <= wdata_d;
  end

  // Storage is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[eff_widx[AW-1:0]] <= (mem_word & ~eff_mask) | (eff_wdata & eff_mask);
  end

  assign o_ready = ready_q;
  assign o_err   = err_q;
  assign o_rdata = rdata_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits (fixed to 32 for this block).
- REQ-002 SHALL have parameter RAM_AMOUNT, default 32, meaning number of 32-bit words in storage (power of two).
- REQ-003 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each response (0..15).
- REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
- REQ-005 SHALL have port rst_n, input, 1 bit, reset; asynchronous and active-low.
- REQ-006 SHALL have port i_rd, input, 1 bit, read request from initiator.
- REQ-007 SHALL have port i_we, input, 1 bit, write request from initiator.
- REQ-008 SHALL have port i_ctrl, input, 4 bits, byte-lane enable; bit n selects byte n (bits 8n+7:8n).
- REQ-009 SHALL have port i_addr, input, 32 bits, byte address; word index = i_addr[31:2].
- REQ-010 SHALL have port i_wdata, input, DATA_WIDTH bits, write data.
- REQ-011 SHALL have port o_rdata, output, DATA_WIDTH bits, read data; valid only while o_ready=1.
- REQ-012 SHALL have port o_ready, output, 1 bit, one-cycle response strobe (read data valid / write committed).
- REQ-013 SHALL have port o_err, output, 1 bit, error flag; valid only while o_ready=1.

Function
- REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
- REQ-015 In IDLE, a rising edge with i_rd=1 or i_we=1 SHALL accept the request: latch i_rd, i_we, i_ctrl, i_addr, i_wdata; load the wait counter with WAIT_CYCLES.
- REQ-016 On acceptance, the FSM SHALL go to WAIT if WAIT_CYCLES>0, else directly to RESP.
- REQ-017 In WAIT, the counter SHALL decrement each edge; at the edge where it reaches 0, the FSM SHALL go to RESP.
- REQ-018 Latency: o_ready SHALL be high exactly in the cycle following acceptance edge + WAIT_CYCLES+1 edges, i.e. WAIT_CYCLES+1 cycles after the accepting edge.
- REQ-019 RESP SHALL last exactly one cycle, then return to IDLE; a request held high at that next edge SHALL be accepted as a new request.
- REQ-020 Inputs SHALL be ignored in WAIT and RESP; latched values alone determine the response.
- REQ-021 Write: on the edge entering RESP, only bytes with latched i_ctrl bit =1 SHALL be updated; other bytes are unchanged.
- REQ-022 Read: o_rdata SHALL present the stored word with disabled byte lanes forced to 0.
- REQ-023 Error: o_err=1 and no storage change SHALL occur when word index >= RAM_AMOUNT, or latched i_ctrl=0000, or both i_rd and i_we were latched high.
- REQ-024 On error, o_rdata SHALL be 0.
- REQ-025 Outside RESP, o_ready=0, o_err=0 and o_rdata=0.
- REQ-026 Storage SHALL be a word array without reset; contents are undefined until written.

Reset
- REQ-027 rst_n=0 SHALL force state IDLE, counter 0 and o_ready=0, o_err=0, o_rdata=0 immediately, regardless of clock.
- REQ-028 Reset mid-operation (WAIT or RESP) SHALL abort the request; a pending write not yet committed SHALL NOT modify storage.
- REQ-029 Storage contents SHALL be preserved across reset.
- REQ-030 The first request SHALL be accepted on the first rising edge with rst_n=1 and a request asserted.

Verification
- REQ-031 WAIT_CYCLES=2: write 0xDEADBEEF, ctrl 1111, addr 100 -> o_ready high 3 cycles after accept, o_err=0; read addr 100 -> o_rdata=0xDEADBEEF.
- REQ-032 Partial write 0x000000AA, ctrl 0001, to addr 100 holding 0x12345678; read ctrl 1111 -> 0x123456AA; read ctrl 0110 -> 0x00345600.
- REQ-033 Read addr 128 (index 32, RAM_AMOUNT=32) -> o_ready=1, o_err=1, o_rdata=0; read addr 124 afterwards -> o_err=0.
- REQ-034 i_rd=i_we=1 to addr 96 with 0x19 -> o_err=1; subsequent read of addr 96 returns its prior value.
- REQ-035 Back-to-back: request held high continuously, WAIT_CYCLES=0 -> o_ready pulses every 2nd cycle, never two consecutive cycles high.
- REQ-036 Write accepted, rst_n low during WAIT -> o_ready stays 0; after release, read shows old contents.
